// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MEM-stage data memory access path.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } mem_state_e;

    localparam int MEM_BYTES_DEF = 256;
    localparam int BYTE_SIZE     = 1;
    localparam int WORD_SIZE     = 2;

    function automatic logic addr_in_range(
        input logic [15:0] addr,
        input logic        word,
        input int          mem_bytes
    );
        int last;
        last = int'(addr) + (word ? WORD_SIZE : BYTE_SIZE);
        return last <= mem_bytes;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects word or low byte of a memory read and sign/zero-extends bytes.
module load_formatter (
    input  logic        word,
    input  logic        is_unsigned,
    input  logic [15:0] raw,
    output logic [15:0] data
);

    logic sign;

    assign sign = raw[7] & ~is_unsigned;
    assign data = word ? raw : {{8{sign}}, raw[7:0]};

endmodule

// File: rtl/mem_access_ctrl.sv
// One-at-a-time load/store controller between the MEM stage and data memory.
module mem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_word,
    input  logic        req_unsigned,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_fault,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_word_en,
    output logic        mem_ld_en,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [15:0] mem_read_data
);

    mem_state_e  state_q, state_d;
    logic        word_q, word_d;
    logic        uns_q, uns_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        word_en_q, word_en_d;
    logic        ld_en_q, ld_en_d;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic        rvalid_q, rvalid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic [15:0] load_data;

    load_formatter u_fmt (
        .word        (word_q),
        .is_unsigned (uns_q),
        .raw         (mem_read_data),
        .data        (load_data)
    );

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        uns_d     = uns_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        word_en_d = word_en_q;
        ld_en_d   = ld_en_q;
        write_d   = 1'b0;
        read_d    = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    word_d = req_word;
                    uns_d  = req_unsigned;
                    if (addr_in_range(req_addr, req_word, MEM_BYTES)) begin
                        state_d = S_ACCESS;
                        addr_d  = req_addr;
                        ld_en_d = ~req_we;
                        write_d = req_we;
                        read_d  = ~req_we;
                        if (req_we) begin
                            word_en_d = req_word;
                            // Byte stores travel on the high lane.
                            wdata_d   = req_word ? req_wdata
                                                 : {req_wdata[7:0], 8'h00};
                        end
                    end else begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        fault_d  = 1'b1;
                        rdata_d  = '0;
                    end
                end
            end
            S_ACCESS: begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
                fault_d  = 1'b0;
                rdata_d  = read_q ? load_data : '0;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            word_q    <= 1'b0;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            word_en_q <= 1'b0;
            ld_en_q   <= 1'b1;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            uns_q     <= uns_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            word_en_q <= word_en_d;
            ld_en_q   <= ld_en_d;
            write_q   <= write_d;
            read_q    <= read_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    // Held low during reset even though the state register sits in IDLE.
    assign req_ready      = rst_n & (state_q == S_IDLE);
    assign resp_valid     = rvalid_q;
    assign resp_rdata     = rdata_q;
    assign resp_fault     = fault_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_word_en    = word_en_q;
    assign mem_ld_en      = ld_en_q;
    assign mem_write      = write_q;
    assign mem_read       = read_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequential load/store controller sitting between the MEM pipeline stage and the 16-bit byte-addressed data memory (256 bytes). It accepts one load/store request at a time over a valid/ready handshake and registers a clean, stable set of memory control signals for one full cycle. It captures and formats the read data (word, sign-/zero-extended byte) and returns a response with a fault flag for out-of-range accesses.

## Interface
- MEM_BYTES, 256, size of data memory in bytes; valid byte addresses are 0..MEM_BYTES-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_word  in  1  1 = 16-bit access, 0 = byte access
- req_unsigned  in  1  byte load zero-extends when 1, sign-extends when 0
- req_addr  in  16  byte address
- req_wdata  in  16  store data; a byte store uses req_wdata[7:0]
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  16  formatted load data; 0 for stores and faults
- resp_fault  out  1  access was out of range; memory was not touched
- mem_addr  out  16  data memory address
- mem_write_data  out  16  data memory write data
- mem_word_en  out  1  1 = word store, 0 = byte store
- mem_ld_en  out  1  driven 1 on every load
- mem_write  out  1  data memory write strobe
- mem_read  out  1  data memory read strobe
- mem_read_data  in  16  data memory read data; little-endian {byte addr+1, byte addr}

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid=1, latch all req_* fields and perform a range check.
  - Word access is legal when addr <= MEM_BYTES-2.
  - Byte access is legal when addr <= MEM_BYTES-1.
  - Legal access goes to ACCESS. Illegal access goes to RESP with the fault flag set.
- ACCESS: all mem_* outputs are driven from registers for exactly one cycle.
  - Store: mem_write=1 and mem_word_en=req_word.
    - Word store: mem_write_data = wdata.
    - Byte store: mem_write_data = {wdata[7:0], 8'h00}. The memory writes the high byte lane on a byte store.
  - Load: mem_read=1 and mem_ld_en=1; the controller always issues a word read.
    - mem_read_data is captured at the end of ACCESS.
    - Word load: rdata = mem_read_data.
    - Byte load: rdata = {8{sign}}, mem_read_data[7:0], with sign = mem_read_data[7] & ~req_unsigned.
  - Always proceed to RESP.
- RESP: resp_valid=1 for one cycle, then return to IDLE. There is no backpressure on the response.
- Outside ACCESS: mem_write=0, mem_read=0, mem_addr holds its last value.
- resp_rdata and resp_fault are valid only while resp_valid=1. At all other times they hold their last value.

## Timing
- Reset values: req_ready=0 while rst_n=0, then 1 in the first cycle after release (IDLE). Every other output resets to 0, except mem_ld_en, which resets to 1.
- Legal access: request accepted at edge N, memory strobe high during cycle N+1, resp_valid during cycle N+2. Throughput is one request per 3 cycles.
- Fault: accepted at edge N, resp_valid during cycle N+1 with resp_fault=1 and resp_rdata=0. No mem strobe is ever asserted.
- req_ready=0 in ACCESS and RESP. A req_valid held high across RESP is accepted in the next IDLE cycle. Request inputs may change freely after acceptance.
- Reset asserted mid-ACCESS forces mem_write and mem_read low immediately and asynchronously, and drops any pending response.

## Structure
- Shared package mips_mem_pkg holds: the FSM state enum, MEM_BYTES default, and byte/word size constants.
- One natural sub-module: load_formatter, a combinational byte/word select plus sign/zero extension. The load path of the pipeline writeback reuses it.

## Test plan
- Word store, then word load: store addr 0x0010 data 0xBEEF; load 0x0010.
  - During the store's ACCESS: mem_write=1, mem_word_en=1, mem_write_data=0xBEEF.
  - The load returns resp_rdata=0xBEEF exactly 2 cycles after acceptance.
- Byte store lane placement: byte store addr 0x0021 wdata 0x1280 drives mem_write_data=0x8000 with mem_word_en=0.
- Byte load extension: memory word 0x3480 at 0x0040.
  - Signed byte load returns 0xFF80.
  - Unsigned byte load returns 0x0080.
- Range faults: all three respond 1 cycle after acceptance with resp_fault=1 and resp_rdata=0, and mem_read/mem_write never assert.
  - Word load at 0x00FF.
  - Byte store at 0x0100.
  - Word load at 0xFFFE.
- Back-to-back: req_valid held high for 3 loads; acceptances are 3 cycles apart, with exactly one resp_valid per request.
- Reset during ACCESS of a store: assert rst_n=0 mid-cycle.
  - mem_write falls immediately.
  - No resp_valid is produced.
  - req_ready=1 in the first cycle after release.
